// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port arbiter between instruction fetch and the load/store buffer.
// Optional IO write back-pressure when MEM_IO_STALL_EN is defined.
module mem_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic [2:0]            ls_op,
  input  logic [31:0]           ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t                r_state;
  logic                  r_is_if;
  logic [2:0]            r_op;
  logic [2:0]            r_n;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [7:0]            r_dout;
  logic                  r_wr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic                  r_if_done;
  logic                  r_ls_done;
  logic [31:0]           r_if_data;
  logic [31:0]           r_ls_rdata;

  logic [2:0]  w_j;
  logic [1:0]  w_bidx;
  logic [31:0] w_full;
  logic [31:0] w_ext;
  logic [2:0]  w_ls_n;
  logic        w_ls_wr;
  logic        w_io_req;
  logic        w_io_cur;
  logic        w_hold_req;
  logic        w_stall;
  logic        w_ls_go;

  assign w_j      = r_cnt + 3'd1;
  assign w_bidx   = r_cnt[1:0] - 2'd1;
  assign w_ls_wr  = ls_op[2] & (ls_op[1] | ls_op[0]);
  assign w_io_req = ls_addr[ADDR_WIDTH-1:0] >= IO_BASE[ADDR_WIDTH-1:0];
  assign w_io_cur = r_a >= IO_BASE[ADDR_WIDTH-1:0];

`ifdef MEM_IO_STALL_EN
  assign w_hold_req = io_buffer_full & w_io_req & w_ls_wr;
  assign w_stall    = io_buffer_full & w_io_cur;
`else
  assign w_hold_req = 1'b0 & io_buffer_full & w_io_req;
  assign w_stall    = 1'b0 & w_io_cur;
`endif

  assign w_ls_go = ls_req & ~w_hold_req;

  always_comb begin
    unique case (1'b1)
      (ls_op == 3'b000), (ls_op == 3'b001),
      (ls_op == 3'b101): w_ls_n = 3'd1;
      (ls_op == 3'b010), (ls_op == 3'b011),
      (ls_op == 3'b110): w_ls_n = 3'd2;
      default:           w_ls_n = 3'd4;
    endcase
  end

  // Result as it will look once the byte arriving this cycle is merged in
  always_comb begin
    w_full = r_buf;
    w_full[{w_bidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    unique case (r_op)
      3'b000:  w_ext = {{24{w_full[7]}}, w_full[7:0]};
      3'b001:  w_ext = {24'b0, w_full[7:0]};
      3'b010:  w_ext = {{16{w_full[15]}}, w_full[15:0]};
      3'b011:  w_ext = {16'b0, w_full[15:0]};
      default: w_ext = w_full;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_is_if    <= 1'b0;
      r_op       <= 3'b000;
      r_n        <= 3'd0;
      r_cnt      <= 3'd0;
      r_a        <= '0;
      r_dout     <= 8'h00;
      r_wr       <= 1'b0;
      r_wdata    <= 32'h0;
      r_buf      <= 32'h0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_rdata <= 32'h0;
    end else if (rdy_in) begin
      r_if_done <= 1'b0;
      r_ls_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!clear && w_ls_go) begin
            r_is_if <= 1'b0;
            r_op    <= ls_op;
            r_n     <= w_ls_n;
            r_cnt   <= 3'd0;
            r_a     <= ls_addr[ADDR_WIDTH-1:0];
            r_wdata <= ls_wdata;
            r_dout  <= ls_wdata[7:0];
            if (w_ls_wr) begin
              r_wr    <= 1'b1;
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end else if (!clear && if_req) begin
            r_is_if <= 1'b1;
            r_op    <= 3'b100;
            r_n     <= 3'd4;
            r_cnt   <= 3'd0;
            r_a     <= if_addr[ADDR_WIDTH-1:0];
            r_state <= S_RD;
          end
        end
        S_RD: begin
          if (clear) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_j;
            if (w_j < r_n) r_a <= r_a + 1'b1;
            if (w_j >= 3'd2) r_buf <= w_full;
            if (w_j == r_n + 3'd1) begin
              r_state <= S_IDLE;
              if (r_is_if) begin
                r_if_done <= 1'b1;
                r_if_data <= w_full;
              end else begin
                r_ls_done  <= 1'b1;
                r_ls_rdata <= w_ext;
              end
            end
          end
        end
        S_WR: begin
          // Stores run to completion even across a flush
          if (!w_stall) begin
            if (w_j == r_n) begin
              r_wr      <= 1'b0;
              r_ls_done <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_cnt  <= w_j;
              r_a    <= r_a + 1'b1;
              r_dout <= r_wdata[{w_j[1:0], 3'b000} +: 8];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_done  = r_if_done;
  assign if_data  = r_if_data;
  assign ls_done  = r_ls_done;
  assign ls_rdata = r_ls_rdata;
  assign mem_a    = r_a;
  assign mem_dout = r_dout;
  assign mem_wr   = r_wr & rdy_in & ~w_stall;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte RAM model.
// IO stall checks follow MEM_IO_STALL_EN.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic [2:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_op          (ls_op),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_a  = '0;
  logic [7:0]  pl_d  = '0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  logic [31:0] sa [0:63];
  logic        sw [0:63];
  logic [7:0]  sd [0:63];

  task automatic run_ls(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int clr_at,
                        input int roff, input int rlen, input int io_len,
                        output logic [31:0] data, output int lat,
                        output int nw);
    int n;
    int w0;
    ls_op    = op;
    ls_addr  = addr;
    ls_wdata = wd;
    ls_req   = 1'b1;
    lat      = -1;
    data     = '0;
    n        = 0;
    w0       = wr_cnt;
    while (lat < 0 && n < 40) begin
      clear          = (n == clr_at);
      rdy_in         = !(n >= roff && n < roff + rlen);
      io_buffer_full = (n < io_len);
      @(negedge clk);
      n++;
      sa[n] = mem_a;
      sw[n] = mem_wr;
      sd[n] = mem_dout;
      if (ls_done) begin
        lat    = n;
        data   = ls_rdata;
        ls_req = 1'b0;
      end
    end
    ls_req         = 1'b0;
    clear          = 1'b0;
    rdy_in         = 1'b1;
    io_buffer_full = 1'b0;
    nw             = wr_cnt - w0;
  endtask

  logic [31:0] d;
  int          lat;
  int          nw;
  int          ln;
  int          fn;
  int          cnt;
  logic        any;

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b1; ls_op = 3'b100; ls_addr = 32'h100; ls_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    check("rst_dones", {30'b0, if_done, ls_done}, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    ls_req = 1'b0;
    rst_n  = 1'b1;

    poke(12'h100, 8'h11); poke(12'h101, 8'h22);
    poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h200, 8'h80);
    poke(12'h210, 8'h00); poke(12'h211, 8'h80);
    poke(12'h600, 8'hEF); poke(12'h601, 8'hBE);
    poke(12'h602, 8'hAD); poke(12'h603, 8'hDE);
    poke(12'hFFF, 8'h34); poke(12'h000, 8'h12);
    @(negedge clk);

    run_ls(3'b100, 32'h100, 0, -1, -1, 0, 0, d, lat, nw);
    check("lw_data", d, 32'h44332211);
    check("lw_lat", lat, 6);
    for (int k = 1; k <= 4; k++)
      check("lw_addr", sa[k], 32'h100 + k - 1);
    check("lw_nowr", {31'b0, sw[1] | sw[2] | sw[3] | sw[4]}, 32'h0);

    run_ls(3'b000, 32'h200, 0, -1, -1, 0, 0, d, lat, nw);
    check("lb_data", d, 32'hFFFFFF80);
    check("lb_lat", lat, 3);
    run_ls(3'b001, 32'h200, 0, -1, -1, 0, 0, d, lat, nw);
    check("lbu_data", d, 32'h00000080);
    run_ls(3'b010, 32'h210, 0, -1, -1, 0, 0, d, lat, nw);
    check("lh_data", d, 32'hFFFF8000);
    check("lh_lat", lat, 4);
    run_ls(3'b011, 32'h210, 0, -1, -1, 0, 0, d, lat, nw);
    check("lhu_data", d, 32'h00008000);

    run_ls(3'b110, 32'h300, 32'h1234ABCD, -1, -1, 0, 0, d, lat, nw);
    check("sh_lat", lat, 3);
    check("sh_a0", sa[1], 32'h300);
    check("sh_d0", {24'b0, sd[1]}, 32'hCD);
    check("sh_w0", {31'b0, sw[1]}, 32'h1);
    check("sh_a1", sa[2], 32'h301);
    check("sh_d1", {24'b0, sd[2]}, 32'hAB);
    check("sh_w1", {31'b0, sw[2]}, 32'h1);
    check("sh_wdone", {31'b0, sw[3]}, 32'h0);
    check("sh_nw", nw, 2);
    @(negedge clk);
    check("sh_wafter", {31'b0, mem_wr}, 32'h0);
    check("sh_ram", {ram[12'h301], ram[12'h300]}, 32'hABCD);

    // Simultaneous requests: LS first, IF right after
    ls_op = 3'b100; ls_addr = 32'h100; ls_req = 1'b1;
    if_addr = 32'h600; if_req = 1'b1;
    ln = -1; fn = -1; cnt = 0;
    for (int n = 1; n <= 30 && fn < 0; n++) begin
      @(negedge clk);
      if (ls_done) begin
        ln = n; d = ls_rdata; ls_req = 1'b0; cnt++;
      end
      if (if_done) begin
        fn = n; check("both_if_data", if_data, 32'hDEADBEEF);
        if_req = 1'b0;
      end
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("both_ls_lat", ln, 6);
    check("both_ls_data", d, 32'h44332211);
    check("both_if_lat", fn, 12);
    check("both_ls_once", cnt, 1);

    // Flush an in-flight fetch
    if_addr = 32'h600; if_req = 1'b1; cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (n == 2) begin clear = 1'b1; if_req = 1'b0; end
      if (n == 3) clear = 1'b0;
      @(negedge clk);
      if (if_done) cnt++;
    end
    check("clr_if_nodone", cnt, 0);
    run_ls(3'b101, 32'h500, 32'h5A, -1, -1, 0, 0, d, lat, nw);
    check("clr_sb_lat", lat, 2);
    check("clr_sb_ram", {24'b0, ram[12'h500]}, 32'h5A);

    run_ls(3'b111, 32'h400, 32'hCAFEF00D, 2, -1, 0, 0, d, lat, nw);
    check("clr_sw_lat", lat, 5);
    check("clr_sw_nw", nw, 4);
    check("clr_sw_ram", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]},
          32'hCAFEF00D);

    run_ls(3'b101, 32'h510, 32'h66, 0, -1, 0, 0, d, lat, nw);
    check("clr_idle_lat", lat, 3);

    run_ls(3'b111, 32'h410, 32'h87654321, -1, 2, 2, 0, d, lat, nw);
    check("rdy_sw_lat", lat, 7);
    check("rdy_sw_nw", nw, 4);
    check("rdy_sw_ram", {ram[12'h413], ram[12'h412], ram[12'h411], ram[12'h410]},
          32'h87654321);

    run_ls(3'b011, 32'hFFFF_FFFF, 0, -1, -1, 0, 0, d, lat, nw);
    check("wrap_a1", sa[2], 32'h0);
    check("wrap_data", d, 32'h00001234);

`ifdef MEM_IO_STALL_EN
    run_ls(3'b101, 32'h0003_0000, 32'h77, -1, -1, 0, 5, d, lat, nw);
    any = 1'b0;
    for (int k = 1; k <= 5; k++) any = any | sw[k];
    check("io_stall_nowr", {31'b0, any}, 32'h0);
    check("io_stall_wr", {31'b0, sw[6]}, 32'h1);
    check("io_stall_lat", lat, 7);
`else
    run_ls(3'b101, 32'h0003_0000, 32'h77, -1, -1, 0, 5, d, lat, nw);
    any = sw[1];
    check("io_nostall_wr", {31'b0, any}, 32'h1);
    check("io_nostall_lat", lat, 2);
`endif
    check("io_ram", {24'b0, ram[12'h000]}, 32'h77);
    check("io_nw", nw, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
